// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller channel among toggle req/ack clients.
// Optional: define SDRAM_ARB_PRIO0_EN to make client 0 strictly highest priority.
module sdram_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_BITS   = 22,
    parameter int DATA_BITS   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CLIENTS-1:0]           cl_req,
    output logic [NUM_CLIENTS-1:0]           cl_ack,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_address,
    input  logic [NUM_CLIENTS*DATA_BITS-1:0] cl_data_write,
    input  logic [NUM_CLIENTS-1:0]           cl_we,
    input  logic [NUM_CLIENTS*2-1:0]         cl_wm,
    output logic [NUM_CLIENTS*DATA_BITS-1:0] cl_data_read,
    output logic                             mem_req,
    input  logic                             mem_ack,
    output logic [ADDR_BITS-1:0]             mem_address,
    output logic [DATA_BITS-1:0]             mem_data_write,
    input  logic [DATA_BITS-1:0]             mem_data_read,
    output logic                             mem_we,
    output logic [1:0]                       mem_wm,
    output logic                             busy
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          ptr_q, grant_q, sel, ptr_next;
    logic [NUM_CLIENTS-1:0] pending;
    logic                   found, grant_en, done;

    logic [ADDR_BITS-1:0]   addr_arr  [NUM_CLIENTS];
    logic [DATA_BITS-1:0]   wdata_arr [NUM_CLIENTS];
    logic [1:0]             wm_arr    [NUM_CLIENTS];
    logic [DATA_BITS-1:0]   rd_arr    [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_arr[i]  = cl_address[i*ADDR_BITS +: ADDR_BITS];
        assign wdata_arr[i] = cl_data_write[i*DATA_BITS +: DATA_BITS];
        assign wm_arr[i]    = cl_wm[i*2 +: 2];
        assign cl_data_read[i*DATA_BITS +: DATA_BITS] = rd_arr[i];
    end

    assign pending  = cl_req ^ cl_ack;
    assign ptr_next = (grant_q == IW'(NUM_CLIENTS-1)) ? '0 : grant_q + IW'(1);

    // First pending client at or after the pointer, wrapping around.
`ifdef SDRAM_ARB_PRIO0_EN
    int scan_idx;
    int scan_base;
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        scan_idx  = 0;
        scan_base = (ptr_q == '0) ? 1 : int'(ptr_q);
        if (pending[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CLIENTS-1; k++) begin
                scan_idx = 1 + ((scan_base - 1 + k) % (NUM_CLIENTS-1));
                if (!found && pending[IW'(scan_idx)]) begin
                    found = 1'b1;
                    sel   = IW'(scan_idx);
                end
            end
        end
    end
`else
    int scan_idx;
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            scan_idx = (int'(ptr_q) + k) % NUM_CLIENTS;
            if (!found && pending[IW'(scan_idx)]) begin
                found = 1'b1;
                sel   = IW'(scan_idx);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (found) state_d = ST_WAIT;
            ST_WAIT: if (mem_ack == mem_req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_en = (state_q == ST_IDLE) && found;
        done     = (state_q == ST_WAIT) && (mem_ack == mem_req);
        busy     = (state_q == ST_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req        <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            mem_we         <= 1'b0;
            mem_wm         <= 2'b11;
            grant_q        <= '0;
            ptr_q          <= '0;
            cl_ack         <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) rd_arr[i] <= '0;
        end else if (grant_en) begin
            mem_address    <= addr_arr[sel];
            mem_data_write <= wdata_arr[sel];
            mem_we         <= cl_we[sel];
            mem_wm         <= wm_arr[sel];
            mem_req        <= ~mem_req;
            grant_q        <= sel;
        end else if (done) begin
            if (!mem_we) rd_arr[grant_q] <= mem_data_read;
            cl_ack[grant_q] <= cl_req[grant_q];
`ifdef SDRAM_ARB_PRIO0_EN
            // Client 0 grants bypass the rotation entirely.
            if (grant_q != '0) ptr_q <= ptr_next;
`else
            ptr_q <= ptr_next;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboarded bench for sdram_arbiter: directed client transactions against a
// latency-configurable controller model; a negedge monitor checks grants and completions.
module tb_sdram_arbiter;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int EW = AW + 1 + DW + 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    cl_req = '0;
    logic [N-1:0]    cl_ack;
    logic [N*AW-1:0] cl_address = '0;
    logic [N*DW-1:0] cl_data_write = '0;
    logic [N-1:0]    cl_we = '0;
    logic [N*2-1:0]  cl_wm = '1;
    logic [N*DW-1:0] cl_data_read;
    logic            mem_req;
    logic            mem_ack = 1'b0;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data_write;
    logic [DW-1:0]   mem_data_read = '0;
    logic            mem_we;
    logic [1:0]      mem_wm;
    logic            busy;

    sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .reset(reset),
        .cl_req(cl_req), .cl_ack(cl_ack), .cl_address(cl_address),
        .cl_data_write(cl_data_write), .cl_we(cl_we), .cl_wm(cl_wm),
        .cl_data_read(cl_data_read),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_address(mem_address),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
        .mem_we(mem_we), .mem_wm(mem_wm), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 6;
    logic [EW-1:0]   exp_q[$];
    logic [2+DW-1:0] rd_q[$];
    logic [DW-1:0]   last_rd[N];

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h9DAA;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic toggle_req(input int c, input logic [AW-1:0] a, input logic we,
                              input logic [DW-1:0] d, input logic [1:0] wm);
        cl_address[c*AW +: AW]    = a;
        cl_data_write[c*DW +: DW] = d;
        cl_we[c]                  = we;
        cl_wm[c*2 +: 2]           = wm;
        cl_req[c]                 = ~cl_req[c];
    endtask

    // Push in the order grants are expected, not the order requests are issued.
    task automatic expect_txn(input int c, input logic [AW-1:0] a, input logic we,
                              input logic [DW-1:0] d, input logic [1:0] wm);
        logic [DW-1:0] rv;
        exp_q.push_back({a, we, d, wm});
        rv = we ? last_rd[c] : rd_fn(a);
        last_rd[c] = rv;
        rd_q.push_back({2'(c), rv});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cl_req == cl_ack && !busy) && n < budget);
        check(name, 64'(cl_req == cl_ack && !busy), 64'(1));
    endtask

    task automatic clear_model();
        exp_q.delete();
        rd_q.delete();
        for (int i = 0; i < N; i++) last_rd[i] = '0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        cl_req = '0;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cl_ack"}, 64'(cl_ack), 64'(0));
        check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        check({tag, "_mem_wm"}, 64'(mem_wm), 64'(2'b11));
        check({tag, "_mem_address"}, 64'(mem_address), 64'(0));
        check({tag, "_mem_data_write"}, 64'(mem_data_write), 64'(0));
        check({tag, "_cl_data_read"}, 64'(cl_data_read), 64'(0));
    endtask

    // Controller model: answers each outstanding request after lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req != mem_ack) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_data_read = rd_fn(mem_address);
                    mem_ack = mem_req;
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a grant or completes one.
    logic          prev_req = 1'b0;
    logic [N-1:0]  prev_ack = '0;
    logic [EW-1:0] hold = '0;
    always @(negedge clk) begin
        logic [EW-1:0]   e;
        logic [2+DW-1:0] r;
        if (!reset) begin
            if (mem_req != prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("grant_fields", 64'({mem_address, mem_we, mem_data_write, mem_wm}), 64'(e));
                end
                check("grant_busy", 64'(busy), 64'(1));
                check("grant_single_outstanding", 64'(mem_req != mem_ack), 64'(1));
                hold = {mem_address, mem_we, mem_data_write, mem_wm};
            end else if (busy) begin
                check("wait_hold_stable", 64'({mem_address, mem_we, mem_data_write, mem_wm}), 64'(hold));
            end
            for (int i = 0; i < N; i++) begin
                if (cl_ack[i] != prev_ack[i]) begin
                    if (rd_q.size() == 0) begin
                        check("unexpected_ack", 64'(rd_q.size()), 64'(1));
                    end else begin
                        r = rd_q.pop_front();
                        check("ack_client", 64'(i), 64'(r[2+DW-1:DW]));
                        check("ack_read_data", 64'(cl_data_read[i*DW +: DW]), 64'(r[DW-1:0]));
                    end
                end
            end
        end
        prev_req = mem_req;
        prev_ack = cl_ack;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single read from client 2, controller answers after 6 cycles.
        lat = 6;
        expect_txn(2, 22'h12345, 1'b0, 16'h0000, 2'b00);
        toggle_req(2, 22'h12345, 1'b0, 16'h0000, 2'b00);
        @(negedge clk);
        check("t1_mem_req", 64'(mem_req), 64'(1));
        check("t1_mem_address", 64'(mem_address), 64'(22'h12345));
        check("t1_mem_we", 64'(mem_we), 64'(0));
        check("t1_busy", 64'(busy), 64'(1));
        n = 0;
        while (mem_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_ack_seen", 64'(mem_ack), 64'(1));
        @(negedge clk);
        check("t1_cl_ack", 64'(cl_ack[2]), 64'(1));
        check("t1_data", 64'(cl_data_read[2*DW +: DW]), 64'(16'hBEEF));
        check("t1_busy_drop", 64'(busy), 64'(0));

        // All four clients at once from reset: order 0,1,2,3.
        do_reset();
        lat = 3;
        expect_txn(0, 22'h00100, 1'b0, 16'h1111, 2'b00);
        expect_txn(1, 22'h00201, 1'b0, 16'h2222, 2'b00);
        expect_txn(2, 22'h00302, 1'b0, 16'h3333, 2'b00);
        expect_txn(3, 22'h00403, 1'b0, 16'h4444, 2'b00);
        toggle_req(0, 22'h00100, 1'b0, 16'h1111, 2'b00);
        toggle_req(1, 22'h00201, 1'b0, 16'h2222, 2'b00);
        toggle_req(2, 22'h00302, 1'b0, 16'h3333, 2'b00);
        toggle_req(3, 22'h00403, 1'b0, 16'h4444, 2'b00);
        wait_idle("t2_idle", 200);

        // Move the pointer to 3, then 1 and 3 together: 3 first, then wrap to 1.
        expect_txn(2, 22'h3A000, 1'b0, 16'h0000, 2'b00);
        toggle_req(2, 22'h3A000, 1'b0, 16'h0000, 2'b00);
        wait_idle("t3_setup_idle", 100);
        expect_txn(3, 22'h3B111, 1'b0, 16'h0000, 2'b00);
        expect_txn(1, 22'h01C22, 1'b0, 16'h0000, 2'b00);
        toggle_req(1, 22'h01C22, 1'b0, 16'h0000, 2'b00);
        toggle_req(3, 22'h3B111, 1'b0, 16'h0000, 2'b00);
        wait_idle("t3_idle", 200);

        // Client 1 write: read register keeps its earlier value.
        expect_txn(1, 22'h2F0F0, 1'b1, 16'hA5A5, 2'b01);
        toggle_req(1, 22'h2F0F0, 1'b1, 16'hA5A5, 2'b01);
        @(negedge clk);
        check("t4_mem_we", 64'(mem_we), 64'(1));
        check("t4_mem_data_write", 64'(mem_data_write), 64'(16'hA5A5));
        check("t4_mem_wm", 64'(mem_wm), 64'(2'b01));
        wait_idle("t4_idle", 100);
        check("t4_read_unchanged", 64'(cl_data_read[1*DW +: DW]), 64'(16'h8188));

        // Clients 0,1,2 pending; client 0 re-requests right after each of its acks.
        do_reset();
        lat = 2;
`ifdef SDRAM_ARB_PRIO0_EN
        expect_txn(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        expect_txn(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        expect_txn(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        expect_txn(1, 22'h11111, 1'b0, 16'h0000, 2'b00);
        expect_txn(2, 22'h12222, 1'b0, 16'h0000, 2'b00);
`else
        expect_txn(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        expect_txn(1, 22'h11111, 1'b0, 16'h0000, 2'b00);
        expect_txn(2, 22'h12222, 1'b0, 16'h0000, 2'b00);
        expect_txn(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        expect_txn(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
`endif
        toggle_req(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        toggle_req(1, 22'h11111, 1'b0, 16'h0000, 2'b00);
        toggle_req(2, 22'h12222, 1'b0, 16'h0000, 2'b00);
        for (int r = 0; r < 2; r++) begin
            int m;
            m = 0;
            @(negedge clk);
            while (cl_ack[0] != cl_req[0] && m < 200) begin
                @(negedge clk);
                m++;
            end
            check("t5_rereq_wait", 64'(cl_ack[0]), 64'(cl_req[0]));
            toggle_req(0, 22'h10000, 1'b0, 16'h0000, 2'b00);
        end
        wait_idle("t5_idle", 300);

        // Reset while a read is outstanding, then a fresh request from client 0.
        lat = 8;
        expect_txn(3, 22'h15555, 1'b0, 16'h0000, 2'b00);
        toggle_req(3, 22'h15555, 1'b0, 16'h0000, 2'b00);
        repeat (3) @(negedge clk);
        check("t6_busy_before_reset", 64'(busy), 64'(1));
        check("t6_data_before_reset", 64'(cl_data_read != '0), 64'(1));
        reset  = 1'b1;
        cl_req = '0;
        clear_model();
        #1;
        check_reset_values("t6_async");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lat = 3;
        expect_txn(0, 22'h0ABCD, 1'b0, 16'h0000, 2'b00);
        toggle_req(0, 22'h0ABCD, 1'b0, 16'h0000, 2'b00);
        wait_idle("t6_idle", 100);
        check("t6_data", 64'(cl_data_read[0*DW +: DW]), 64'(16'h3667));

        repeat (2) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("rd_q_empty", 64'(rd_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
